// File: rtl/audio_adc_rx.sv
// audio_adc_rx: I2S / left-justified serial ADC receiver with pin
// synchronisers, a word-capture FSM and a first-word-fall-through FIFO.
module audio_adc_rx #(
   parameter int SAMPLE_WIDTH = 16,
   parameter int CHANNELS     = 2,
   parameter int MODE         = 0,
   parameter int FIFO_DEPTH   = 8
) (
   input  logic                        clk_clk,
   input  logic                        reset_reset_n,
   input  logic                        audio_ADCDAT,
   input  logic                        audio_ADCLRCK,
   input  logic                        audio_BCLK,
   input  logic                        enable,
   input  logic                        clear_overflow,
   output logic                        out_valid,
   input  logic                        out_ready,
   output logic [SAMPLE_WIDTH-1:0]     out_data,
   output logic                        out_channel,
   output logic [$clog2(FIFO_DEPTH):0] fill_level,
   output logic                        overflow,
   output logic                        short_word
);
   localparam int CW = $clog2(SAMPLE_WIDTH);
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int FW = AW + 1;
   localparam int EW = SAMPLE_WIDTH + 1;

   typedef enum logic [1:0] {IDLE, ARM, SHIFT, WAIT} state_t;

   logic [2:0]              bclk_q, bclk_d;
   logic [1:0]              lrck_q, lrck_d;
   logic [1:0]              dat_q, dat_d;
   logic                    lr_prev_q, lr_prev_d;
   logic                    lr_seen_q, lr_seen_d;
   logic                    strobe, lrck_s, dat_s;
   logic                    lr_chg, new_ch;

   state_t                  state_q, state_d;
   logic [SAMPLE_WIDTH-1:0] shift_q, shift_d, shift_in;
   logic [CW-1:0]           cnt_q, cnt_d;
   logic                    chan_q, chan_d;
   logic                    push_q, push_d;
   logic                    short_q, short_d;

   logic [EW-1:0]           mem_q [FIFO_DEPTH];
   logic [AW-1:0]           wr_q, wr_d, rd_q, rd_d;
   logic [FW-1:0]           fill_q, fill_d;
   logic                    ovf_q, ovf_d;
   logic                    full, pop, wr_en;

   // lr_seen gates change detection so a mid-frame start is never a "change"
   always_comb begin
      bclk_d    = {bclk_q[1:0], audio_BCLK};
      lrck_d    = {lrck_q[0], audio_ADCLRCK};
      dat_d     = {dat_q[0], audio_ADCDAT};
      strobe    = bclk_q[1] & ~bclk_q[2];
      lrck_s    = lrck_q[1];
      dat_s     = dat_q[1];
      lr_chg    = strobe & lr_seen_q & (lrck_s != lr_prev_q);
      new_ch    = (MODE == 0) ? lrck_s : ~lrck_s;
      lr_prev_d = strobe ? lrck_s : lr_prev_q;
      lr_seen_d = lr_seen_q | strobe;
      shift_in  = {shift_q[SAMPLE_WIDTH-2:0], dat_s};
   end

   always_comb begin
      state_d = state_q;
      shift_d = shift_q;
      cnt_d   = cnt_q;
      chan_d  = chan_q;
      push_d  = 1'b0;
      short_d = 1'b0;
      if (!enable) begin
         state_d = IDLE;
      end else if (lr_chg) begin
         chan_d  = new_ch;
         short_d = (state_q == SHIFT);
         if (MODE == 0) begin
            state_d = ARM;
            cnt_d   = '0;
         end else begin
            state_d = SHIFT;
            shift_d = shift_in;
            cnt_d   = CW'(1);
         end
      end else if (strobe) begin
         unique case (state_q)
            ARM: begin
               shift_d = shift_in;
               cnt_d   = CW'(1);
               state_d = SHIFT;
            end
            SHIFT: begin
               shift_d = shift_in;
               if (cnt_q == CW'(SAMPLE_WIDTH - 1)) begin
                  state_d = WAIT;
                  cnt_d   = '0;
                  push_d  = (CHANNELS == 2) || !chan_q;
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   // a push into a full FIFO still lands if the head leaves this cycle
   always_comb begin
      full        = (fill_q == FW'(FIFO_DEPTH));
      out_valid   = (fill_q != '0);
      pop         = out_valid & out_ready;
      wr_en       = push_q & (~full | pop);
      wr_d        = wr_en ? wr_q + 1'b1 : wr_q;
      rd_d        = pop ? rd_q + 1'b1 : rd_q;
      fill_d      = fill_q + FW'(wr_en) - FW'(pop);
      ovf_d       = (ovf_q & ~clear_overflow) | (push_q & ~wr_en);
      out_data    = mem_q[rd_q][SAMPLE_WIDTH-1:0];
      out_channel = mem_q[rd_q][SAMPLE_WIDTH];
      fill_level  = fill_q;
      overflow    = ovf_q;
      short_word  = short_q;
   end

   always_ff @(posedge clk_clk or negedge reset_reset_n) begin
      if (!reset_reset_n) begin
         bclk_q    <= '0;
         lrck_q    <= '0;
         dat_q     <= '0;
         lr_prev_q <= 1'b0;
         lr_seen_q <= 1'b0;
         state_q   <= IDLE;
         shift_q   <= '0;
         cnt_q     <= '0;
         chan_q    <= 1'b0;
         push_q    <= 1'b0;
         short_q   <= 1'b0;
         wr_q      <= '0;
         rd_q      <= '0;
         fill_q    <= '0;
         ovf_q     <= 1'b0;
         for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
      end else begin
         bclk_q    <= bclk_d;
         lrck_q    <= lrck_d;
         dat_q     <= dat_d;
         lr_prev_q <= lr_prev_d;
         lr_seen_q <= lr_seen_d;
         state_q   <= state_d;
         shift_q   <= shift_d;
         cnt_q     <= cnt_d;
         chan_q    <= chan_d;
         push_q    <= push_d;
         short_q   <= short_d;
         wr_q      <= wr_d;
         rd_q      <= rd_d;
         fill_q    <= fill_d;
         ovf_q     <= ovf_d;
         if (wr_en) mem_q[wr_q] <= {chan_q, shift_q};
      end
   end

endmodule

// File: tb/tb_audio_adc_rx.sv
// Bench for audio_adc_rx: four configurations share one pin stream and are
// checked against a frame-level model of the expected captured words.
module tb_audio_adc_rx;
   localparam int BH = 4;

   typedef logic [16:0] word_q_t [$];

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        dat = 1'b0;
   logic        lrck = 1'b0;
   logic        bclk = 1'b0;
   logic [3:0]  en = '0;
   logic [3:0]  clr = '0;
   logic [3:0]  rdy = '0;
   logic [3:0]  v, ch, ovf, sw;
   logic [15:0] d [4];
   logic [3:0]  fl [4];

   word_q_t     got [4];
   word_q_t     expq [4];
   int          swc [4];
   int          m_short [4];
   logic [3:0]  m_ovf;
   bit          m_seen;
   bit          m_last;
   int          ncmp = 0;
   int          nerr = 0;

   always #5 clk = ~clk;

   // dut0 I2S stereo, dut1 left-justified, dut2 mono, dut3 depth 4
   for (genvar g = 0; g < 4; g++) begin : g_dut
      localparam int MD = (g == 1) ? 1 : 0;
      localparam int CH = (g == 2) ? 1 : 2;
      localparam int DP = (g == 3) ? 4 : 8;
      logic [$clog2(DP):0] flw;
      audio_adc_rx #(
         .SAMPLE_WIDTH(16), .CHANNELS(CH), .MODE(MD), .FIFO_DEPTH(DP)
      ) u_dut (
         .clk_clk(clk), .reset_reset_n(rst_n),
         .audio_ADCDAT(dat), .audio_ADCLRCK(lrck), .audio_BCLK(bclk),
         .enable(en[g]), .clear_overflow(clr[g]),
         .out_valid(v[g]), .out_ready(rdy[g]),
         .out_data(d[g]), .out_channel(ch[g]),
         .fill_level(flw), .overflow(ovf[g]), .short_word(sw[g])
      );
      assign fl[g] = 4'(flw);
   end

   // records every handshake and short_word pulse
   always @(negedge clk) begin
      for (int i = 0; i < 4; i++) begin
         if (rst_n && v[i] && rdy[i]) got[i].push_back({ch[i], d[i]});
         if (sw[i]) swc[i]++;
      end
   end

   initial begin
      #2ms;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1);
   end

   function automatic void model_clear();
      for (int i = 0; i < 4; i++) begin
         got[i].delete();
         expq[i].delete();
         swc[i] = 0;
         m_short[i] = 0;
      end
      m_ovf = '0;
      m_seen = 1'b0;
   endfunction

   // a half-frame yields a word only if it follows an observed LRCK change
   function automatic void model_half(bit lr, logic [31:0] raw, int n);
      bit lj, chn;
      int need, depth;
      logic [15:0] w;
      for (int i = 0; i < 4; i++) begin
         lj = (i == 1);
         need = lj ? 16 : 17;
         depth = (i == 3) ? 4 : 8;
         chn = lj ? !lr : lr;
         w = lj ? raw[31:16] : raw[30:15];
         if (en[i] && m_seen && lr != m_last) begin
            if (n < need) m_short[i]++;
            else if (i == 2 && chn) begin end
            else if (!rdy[i] && expq[i].size() >= depth) m_ovf[i] = 1'b1;
            else expq[i].push_back({chn, w});
         end
      end
      if (n > 0) begin
         m_seen = 1'b1;
         m_last = lr;
      end
   endfunction

   task automatic tick(int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic send_half(bit lr, logic [31:0] raw, int n);
      model_half(lr, raw, n);
      for (int k = 0; k < n; k++) begin
         lrck = lr;
         dat = raw[31-k];
         tick(BH);
         bclk = 1'b1;
         tick(BH);
         bclk = 1'b0;
      end
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      tick(2);
      model_clear();
      rst_n = 1'b1;
      tick(2);
   endtask

   task automatic test_reset();
      tick(3);
      for (int i = 0; i < 4; i++) begin
         ncmp += 6;
         if (v[i] !== 1'b0) begin nerr++; $display("FAIL rst_valid dut%0d: got %b want 0", i, v[i]); end
         if (d[i] !== 16'h0) begin nerr++; $display("FAIL rst_data dut%0d: got %h want 0", i, d[i]); end
         if (ch[i] !== 1'b0) begin nerr++; $display("FAIL rst_chan dut%0d: got %b want 0", i, ch[i]); end
         if (fl[i] !== 4'd0) begin nerr++; $display("FAIL rst_fill dut%0d: got %0d want 0", i, fl[i]); end
         if (ovf[i] !== 1'b0) begin nerr++; $display("FAIL rst_ovf dut%0d: got %b want 0", i, ovf[i]); end
         if (sw[i] !== 1'b0) begin nerr++; $display("FAIL rst_short dut%0d: got %b want 0", i, sw[i]); end
      end
   endtask

   task automatic test_i2s_stereo();
      logic [31:0] r;
      do_reset();
      rdy = 4'hF;
      en = 4'hF;
      send_half(1'b1, $urandom(), 32);
      r = $urandom(); r[30:15] = 16'hA5C3; r[31:16] = r[31:16];
      send_half(1'b0, r, 32);
      r = $urandom(); r[30:15] = 16'h1234;
      send_half(1'b1, r, 32);
      send_half(1'b0, $urandom(), 32);
      send_half(1'b1, $urandom(), 32);
      tick(12);
      ncmp += 2;
      if (got[0].size() < 2) begin
         nerr += 2; $display("FAIL i2s_first: got %0d words want >=2", got[0].size());
      end else begin
         if (got[0][0] !== {1'b0, 16'hA5C3}) begin nerr++; $display("FAIL i2s_left: got %h want %h", got[0][0], {1'b0, 16'hA5C3}); end
         if (got[0][1] !== {1'b1, 16'h1234}) begin nerr++; $display("FAIL i2s_right: got %h want %h", got[0][1], {1'b1, 16'h1234}); end
      end
      for (int i = 0; i < 4; i++) begin
         ncmp += 2;
         if (ovf[i] !== 1'b0) begin nerr++; $display("FAIL i2s_ovf dut%0d: got %b want 0", i, ovf[i]); end
         if (swc[i] != m_short[i]) begin nerr++; $display("FAIL i2s_short dut%0d: got %0d want %0d", i, swc[i], m_short[i]); end
         ncmp++;
         if (got[i].size() != expq[i].size()) begin
            nerr++; $display("FAIL i2s_count dut%0d: got %0d want %0d", i, got[i].size(), expq[i].size());
         end else for (int k = 0; k < got[i].size(); k++) begin
            ncmp++;
            if (got[i][k] !== expq[i][k]) begin nerr++; $display("FAIL i2s_word dut%0d[%0d]: got %h want %h", i, k, got[i][k], expq[i][k]); end
         end
      end
   endtask

   task automatic test_left_justified();
      logic [31:0] r;
      do_reset();
      rdy = 4'hF;
      en = 4'hF;
      send_half(1'b0, $urandom(), 32);
      r = $urandom(); r[31:16] = 16'h8001;
      send_half(1'b1, r, 32);
      send_half(1'b0, $urandom(), 32);
      send_half(1'b1, $urandom(), 32);
      tick(12);
      ncmp++;
      if (got[1].size() < 1 || got[1][0] !== {1'b0, 16'h8001}) begin
         nerr++; $display("FAIL lj_first: got %0d words head %h want %h", got[1].size(), got[1].size() ? got[1][0] : 17'h0, {1'b0, 16'h8001});
      end
      for (int i = 0; i < 4; i++) begin
         ncmp++;
         if (got[i].size() != expq[i].size()) begin
            nerr++; $display("FAIL lj_count dut%0d: got %0d want %0d", i, got[i].size(), expq[i].size());
         end else for (int k = 0; k < got[i].size(); k++) begin
            ncmp++;
            if (got[i][k] !== expq[i][k]) begin nerr++; $display("FAIL lj_word dut%0d[%0d]: got %h want %h", i, k, got[i][k], expq[i][k]); end
         end
      end
   endtask

   task automatic test_mono();
      do_reset();
      rdy = 4'hF;
      en = 4'hF;
      send_half(1'b1, $urandom(), 32);
      for (int f = 0; f < 3; f++) begin
         send_half(1'b0, $urandom(), 32);
         send_half(1'b1, $urandom(), 32);
      end
      tick(12);
      ncmp++;
      if (got[2].size() != 3) begin nerr++; $display("FAIL mono_pops: got %0d want 3", got[2].size()); end
      for (int i = 0; i < 4; i++) begin
         ncmp++;
         if (got[i].size() != expq[i].size()) begin
            nerr++; $display("FAIL mono_count dut%0d: got %0d want %0d", i, got[i].size(), expq[i].size());
         end else for (int k = 0; k < got[i].size(); k++) begin
            ncmp++;
            if (got[i][k] !== expq[i][k]) begin nerr++; $display("FAIL mono_word dut%0d[%0d]: got %h want %h", i, k, got[i][k], expq[i][k]); end
         end
      end
   endtask

   task automatic test_overflow();
      do_reset();
      rdy = 4'b0111;
      en = 4'hF;
      send_half(1'b1, $urandom(), 32);
      for (int h = 0; h < 5; h++) send_half(h[0], $urandom(), 32);
      tick(12);
      ncmp += 3;
      if (fl[3] !== 4'd4) begin nerr++; $display("FAIL ovf_fill: got %0d want 4", fl[3]); end
      if (ovf[3] !== m_ovf[3]) begin nerr++; $display("FAIL ovf_flag: got %b want %b", ovf[3], m_ovf[3]); end
      if (ovf[0] !== 1'b0) begin nerr++; $display("FAIL ovf_dut0: got %b want 0", ovf[0]); end
      rdy[3] = 1'b1;
      tick(12);
      for (int i = 0; i < 4; i++) begin
         ncmp++;
         if (got[i].size() != expq[i].size()) begin
            nerr++; $display("FAIL ovf_count dut%0d: got %0d want %0d", i, got[i].size(), expq[i].size());
         end else for (int k = 0; k < got[i].size(); k++) begin
            ncmp++;
            if (got[i][k] !== expq[i][k]) begin nerr++; $display("FAIL ovf_word dut%0d[%0d]: got %h want %h", i, k, got[i][k], expq[i][k]); end
         end
      end
      ncmp++;
      if (ovf[3] !== 1'b1) begin nerr++; $display("FAIL ovf_sticky: got %b want 1", ovf[3]); end
      clr[3] = 1'b1;
      tick(1);
      clr[3] = 1'b0;
      ncmp++;
      if (ovf[3] !== 1'b0) begin nerr++; $display("FAIL ovf_clear: got %b want 0", ovf[3]); end
   endtask

   task automatic test_short_word();
      do_reset();
      rdy = 4'hF;
      en = 4'hF;
      send_half(1'b1, $urandom(), 32);
      send_half(1'b0, $urandom(), 10);
      send_half(1'b1, $urandom(), 32);
      send_half(1'b0, $urandom(), 32);
      tick(12);
      ncmp++;
      if (swc[0] != 1) begin nerr++; $display("FAIL short_pulse: got %0d want 1", swc[0]); end
      for (int i = 0; i < 4; i++) begin
         ncmp += 2;
         if (swc[i] != m_short[i]) begin nerr++; $display("FAIL short_cnt dut%0d: got %0d want %0d", i, swc[i], m_short[i]); end
         if (got[i].size() != expq[i].size()) begin
            nerr++; $display("FAIL short_count dut%0d: got %0d want %0d", i, got[i].size(), expq[i].size());
         end else for (int k = 0; k < got[i].size(); k++) begin
            ncmp++;
            if (got[i][k] !== expq[i][k]) begin nerr++; $display("FAIL short_word dut%0d[%0d]: got %h want %h", i, k, got[i][k], expq[i][k]); end
         end
      end
   endtask

   task automatic test_reset_mid();
      do_reset();
      rdy = 4'b1110;
      en = 4'hF;
      send_half(1'b1, $urandom(), 32);
      send_half(1'b0, $urandom(), 32);
      send_half(1'b1, $urandom(), 32);
      tick(12);
      ncmp += 2;
      if (fl[0] !== 4'(expq[0].size())) begin nerr++; $display("FAIL rmid_fill: got %0d want %0d", fl[0], expq[0].size()); end
      if (v[0] !== 1'b1) begin nerr++; $display("FAIL rmid_valid: got %b want 1", v[0]); end
      rst_n = 1'b0;
      #1;
      ncmp += 2;
      if (fl[0] !== 4'd0) begin nerr++; $display("FAIL rmid_flush: got %0d want 0", fl[0]); end
      if (v[0] !== 1'b0) begin nerr++; $display("FAIL rmid_vflush: got %b want 0", v[0]); end
      model_clear();
      rdy = 4'hF;
      fork
         send_half(1'b0, $urandom(), 32);
         begin tick(5 * 2 * BH); rst_n = 1'b1; end
      join
      send_half(1'b1, $urandom(), 32);
      send_half(1'b0, $urandom(), 32);
      tick(12);
      for (int i = 0; i < 4; i++) begin
         ncmp++;
         if (got[i].size() != expq[i].size()) begin
            nerr++; $display("FAIL rmid_count dut%0d: got %0d want %0d", i, got[i].size(), expq[i].size());
         end else for (int k = 0; k < got[i].size(); k++) begin
            ncmp++;
            if (got[i][k] !== expq[i][k]) begin nerr++; $display("FAIL rmid_word dut%0d[%0d]: got %h want %h", i, k, got[i][k], expq[i][k]); end
         end
      end
   endtask

   task automatic test_enable_mid();
      do_reset();
      rdy = 4'hF;
      en = 4'h0;
      send_half(1'b1, $urandom(), 32);
      fork
         send_half(1'b0, $urandom(), 32);
         begin tick(6 * 2 * BH); en = 4'hF; end
      join
      send_half(1'b1, $urandom(), 32);
      send_half(1'b0, $urandom(), 32);
      send_half(1'b1, $urandom(), 32);
      fork
         send_half(1'b0, $urandom(), 32);
         begin tick(8 * 2 * BH); en = 4'h0; end
      join
      // the half-frame cut short by enable falling yields no word anywhere
      for (int i = 0; i < 4; i++) void'(expq[i].pop_back());
      en = 4'hF;
      send_half(1'b1, $urandom(), 32);
      send_half(1'b0, $urandom(), 32);
      tick(12);
      for (int i = 0; i < 4; i++) begin
         ncmp += 2;
         if (swc[i] != 0) begin nerr++; $display("FAIL en_short dut%0d: got %0d want 0", i, swc[i]); end
         if (got[i].size() != expq[i].size()) begin
            nerr++; $display("FAIL en_count dut%0d: got %0d want %0d", i, got[i].size(), expq[i].size());
         end else for (int k = 0; k < got[i].size(); k++) begin
            ncmp++;
            if (got[i][k] !== expq[i][k]) begin nerr++; $display("FAIL en_word dut%0d[%0d]: got %h want %h", i, k, got[i][k], expq[i][k]); end
         end
      end
   endtask

   initial begin
      test_reset();
      test_i2s_stereo();
      test_left_justified();
      test_mono();
      test_overflow();
      test_short_word();
      test_reset_mid();
      test_enable_mid();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
      $finish;
   end

endmodule
